// File: rtl/seq_count_3b_wrap_mon.sv
// Checks a 3-bit up/down counter's output sequence against the commanded direction,
// pulsing on 7->0 / 0->7 wraps and keeping a saturating signed net wrap count.
module seq_count_3b_wrap_mon #(
  parameter int WRAP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     op,
  input  logic [2:0]               count,
  input  logic                     clear,
  output logic                     valid,
  output logic                     wrap_up,
  output logic                     wrap_dn,
  output logic                     err,
  output logic signed [WRAP_W-1:0] wraps
);

  typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;

  localparam logic signed [WRAP_W-1:0] WMAX = {1'b0, {(WRAP_W-1){1'b1}}};
  localparam logic signed [WRAP_W-1:0] WMIN = {1'b1, {(WRAP_W-1){1'b0}}};
  localparam logic signed [WRAP_W-1:0] ONE  = WRAP_W'(1);

  state_t                     state, state_nx;
  logic [2:0]                 prev_count, expected;
  logic                       prev_op;
  logic                       valid_nx, up_nx, dn_nx, err_nx;
  logic signed [WRAP_W-1:0]   wraps_nx;

  always_comb begin
    expected = prev_op ? (prev_count - 3'd1) : (prev_count + 3'd1);
    state_nx = state;
    valid_nx = valid;
    up_nx    = 1'b0;
    dn_nx    = 1'b0;
    err_nx   = err;
    wraps_nx = wraps;
    case (state)
      INIT: begin
        state_nx = TRACK;
        valid_nx = 1'b0;
      end
      TRACK: begin
        valid_nx = 1'b1;
        if (count == expected) begin
          // A legal step that crosses the 7/0 boundary is a wrap in the commanded direction
          up_nx = !prev_op && (prev_count == 3'd7);
          dn_nx =  prev_op && (prev_count == 3'd0);
          if (up_nx && wraps != WMAX)
            wraps_nx = wraps + ONE;
          else if (dn_nx && wraps != WMIN)
            wraps_nx = wraps - ONE;
        end else begin
          err_nx   = 1'b1;
          state_nx = FAULT;
        end
      end
      FAULT: begin
        valid_nx = 1'b1;
        err_nx   = 1'b1;
      end
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= INIT;
      prev_count <= 3'd0;
      prev_op    <= 1'b0;
      valid      <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_dn    <= 1'b0;
      err        <= 1'b0;
      wraps      <= '0;
    end else if (clear) begin
      // Sample history is kept; only the monitor state restarts
      state   <= INIT;
      valid   <= 1'b0;
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
      err     <= 1'b0;
      wraps   <= '0;
    end else begin
      state      <= state_nx;
      prev_count <= count;
      prev_op    <= op;
      valid      <= valid_nx;
      wrap_up    <= up_nx;
      wrap_dn    <= dn_nx;
      err        <= err_nx;
      wraps      <= wraps_nx;
    end
  end

endmodule
